// File: rtl/arm_multicycle_controller_if.sv
// arm_multicycle_controller_if
// Bundles the signals between the multicycle controller and the ARM datapath.
//   Instr      datapath -> controller  Instr[31:12] from the instruction register
//   ALUFlags   datapath -> controller  {N,Z,C,V} from the ALU
//   mem_ready  memory   -> controller  memory access completes this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl, ImmSrc, RegSrc  controller -> datapath controls
// master = controller side, slave = datapath/memory side.
interface arm_multicycle_controller_if;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        mem_ready;
   logic        PCWrite;
   logic        IRWrite;
   logic        MemWrite;
   logic        RegWrite;
   logic        AdrSrc;
   logic [1:0]  ResultSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUControl;
   logic [1:0]  ImmSrc;
   logic [1:0]  RegSrc;

   modport master (
      input  Instr, ALUFlags, mem_ready,
      output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
   );

   modport slave (
      output Instr, ALUFlags, mem_ready,
      input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
   );
endinterface

// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller
// Multicycle main controller for the ARM core. Decodes Instr[31:12], holds
// the NZCV flags, evaluates the condition field and steps the shared ALU,
// register file and unified memory through FETCH..WB states, waiting on the
// memory ready handshake. Control outputs are decoded from the state register.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; forces all write enables low
//   bus          arm_multicycle_controller_if.master (instruction, flags,
//                mem_ready in; datapath controls out)
//   state_o      current state encoding (debug)
//   cycle_count  cycles since reset         (PERF_W bits)
//   instr_count  instructions fetched       (PERF_W bits)
// Optional feature: define ARM_CTRL_PERF_EN to build the performance counters;
// without it cycle_count/instr_count read as zero.
module arm_multicycle_controller #(
   parameter int PERF_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   arm_multicycle_controller_if.master bus,
   output logic [3:0]           state_o,
   output logic [PERF_W-1:0]    cycle_count,
   output logic [PERF_W-1:0]    instr_count
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t     state;
   logic [3:0] flags;
   logic       cond_ex;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cmd;
   logic       unused_rn;

   logic       cmd_ok;
   logic       is_cmp;
   logic       is_arith;
   logic [1:0] cmd_alu;
   logic       cond_now;

   logic       pc_raw;
   logic       ir_raw;
   logic       mem_raw;
   logic       reg_raw;
   logic       after_decode;

   // Field extraction; Instr holds bits 31:12 so bit n of the instruction
   // sits at index n-12. Rn (bits 7:4 here) is not needed by the controller.
   assign cond      = bus.Instr[19:16];
   assign op        = bus.Instr[15:14];
   assign funct     = bus.Instr[13:8];
   assign rd        = bus.Instr[3:0];
   assign cmd       = funct[4:1];
   assign unused_rn = &{1'b0, bus.Instr[7:4]};

   // ARM condition evaluation against the held NZCV flags.
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'b0000: cond_holds = z;
         4'b0001: cond_holds = !z;
         4'b0010: cond_holds = cf;
         4'b0011: cond_holds = !cf;
         4'b0100: cond_holds = n;
         4'b0101: cond_holds = !n;
         4'b0110: cond_holds = v;
         4'b0111: cond_holds = !v;
         4'b1000: cond_holds = cf && !z;
         4'b1001: cond_holds = !cf || z;
         4'b1010: cond_holds = (n == v);
         4'b1011: cond_holds = (n != v);
         4'b1100: cond_holds = !z && (n == v);
         4'b1101: cond_holds = z || (n != v);
         4'b1110: cond_holds = 1'b1;
         default: cond_holds = 1'b0;
      endcase
   endfunction

   // Data-processing command decode: which commands are supported, which
   // touch C/V, and the ALU operation each one needs.
   always_comb begin
      cmd_ok   = 1'b1;
      is_cmp   = 1'b0;
      is_arith = 1'b0;
      cmd_alu  = 2'b00;
      case (cmd)
         4'b0100: begin cmd_alu = 2'b00; is_arith = 1'b1; end
         4'b0010: begin cmd_alu = 2'b01; is_arith = 1'b1; end
         4'b0000: cmd_alu = 2'b10;
         4'b1100: cmd_alu = 2'b11;
         4'b1010: begin cmd_alu = 2'b01; is_arith = 1'b1; is_cmp = 1'b1; end
         default: cmd_ok = 1'b0;
      endcase
   end

   assign cond_now = cond_holds(cond, flags);

   // State register, flag register and the latched condition result.
   // DECODE both latches cond_ex and uses the same freshly evaluated value to
   // drop failed or unsupported instructions straight back to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         flags   <= 4'b0000;
         cond_ex <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (bus.mem_ready) state <= DECODE;
            end
            DECODE: begin
               cond_ex <= cond_now;
               if (!cond_now || op == 2'b11 || (op == 2'b00 && !cmd_ok))
                  state <= FETCH;
               else if (op == 2'b01)
                  state <= MEMADR;
               else if (op == 2'b10)
                  state <= BRANCH;
               else if (funct[5])
                  state <= EXECI;
               else
                  state <= EXECR;
            end
            MEMADR: begin
               state <= funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
               if (bus.mem_ready) state <= MEMWB;
            end
            MEMWR: begin
               if (bus.mem_ready) state <= FETCH;
            end
            EXECR, EXECI: begin
               // Logical ops leave C and V untouched.
               if (funct[0] && cond_ex) begin
                  flags[3:2] <= bus.ALUFlags[3:2];
                  if (is_arith) flags[1:0] <= bus.ALUFlags[1:0];
               end
               state <= is_cmp ? FETCH : ALUWB;
            end
            MEMWB, ALUWB, BRANCH: begin
               state <= FETCH;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   // Control decode of the current state. Raw enables are computed here and
   // gated below; selects default to zero and ImmSrc always follows Op.
   always_comb begin
      pc_raw         = 1'b0;
      ir_raw         = 1'b0;
      mem_raw        = 1'b0;
      reg_raw        = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ResultSrc  = 2'b00;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.ALUControl = 2'b00;
      bus.ImmSrc     = op;
      bus.RegSrc     = 2'b00;
      case (state)
         FETCH: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            ir_raw        = bus.mem_ready;
            pc_raw        = bus.mem_ready;
         end
         DECODE: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         MEMADR: begin
            bus.ALUSrcB = 2'b01;
         end
         MEMRD: begin
            bus.AdrSrc = 1'b1;
         end
         MEMWR: begin
            bus.AdrSrc = 1'b1;
            bus.RegSrc = 2'b10;
            mem_raw    = 1'b1;
         end
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            reg_raw       = 1'b1;
            pc_raw        = (rd == 4'd15);
         end
         EXECR: begin
            bus.ALUControl = cmd_alu;
         end
         EXECI: begin
            bus.ALUSrcB    = 2'b01;
            bus.ALUControl = cmd_alu;
         end
         ALUWB: begin
            reg_raw = 1'b1;
            pc_raw  = (rd == 4'd15);
         end
         BRANCH: begin
            bus.RegSrc    = 2'b01;
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            pc_raw        = 1'b1;
         end
         default: begin
            bus.ImmSrc = op;
         end
      endcase
   end

   // Writes past DECODE only happen for instructions whose condition held,
   // and nothing is written while reset is high.
   assign after_decode = (state != FETCH) && (state != DECODE);

   assign bus.PCWrite  = !reset && pc_raw  && (!after_decode || cond_ex);
   assign bus.IRWrite  = !reset && ir_raw;
   assign bus.MemWrite = !reset && mem_raw && (!after_decode || cond_ex);
   assign bus.RegWrite = !reset && reg_raw && (!after_decode || cond_ex);

   assign state_o = state;

`ifdef ARM_CTRL_PERF_EN
   logic [PERF_W-1:0] cycle_q;
   logic [PERF_W-1:0] instr_q;

   // Free-running performance counters; both wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_q + PERF_W'(1);
         if (state == FETCH && bus.mem_ready) instr_q <= instr_q + PERF_W'(1);
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule
